dpb_pingpong_ctrl: RTL and testbench

DPB_PINGPONG_CTRL -- requirements
Module: dpb_pingpong_ctrl

---
 rtl/dpb_pingpong_ctrl.sv | 177 +++++++++++++++++
 tb/tb_dpb_pingpong_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpb_pingpong_ctrl.sv
// Ping-pong frame buffer controller: fills one BRAM bank while the other is streamed
// out through a 4-entry FIFO that absorbs the one-cycle BRAM read latency.
module dpb_pingpong_ctrl #(
  parameter int FRAME_LEN = 512,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic [9:0]        ram_ada,
  output logic [DATA_W-1:0] ram_dina,
  output logic              ram_cea,
  output logic              ram_wrea,
  output logic [9:0]        ram_adb,
  output logic              ram_ceb,
  output logic              ram_wreb,
  input  logic [DATA_W-1:0] ram_doutb,
  output logic              ram_ocea,
  output logic              ram_oceb,
  output logic              ram_reseta,
  output logic              ram_resetb,
  output logic [1:0]        bank_full,
  output logic              wr_bank
);

  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] CNT_MAX = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    B_EMPTY   = 2'd0,
    B_FULL    = 2'd1,
    B_READING = 2'd2
  } bank_st_e;

  bank_st_e        bank_q [2];
  bank_st_e        bank_d [2];
  logic            wr_bank_q, wr_bank_d;
  logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
  logic            iss_bank_q, iss_bank_d;
  logic [CW-1:0]   iss_cnt_q, iss_cnt_d;
  logic            rd_bank_q, rd_bank_d;
  logic            infl_q, infl_d;
  logic            infl_last_q, infl_last_d;

  logic [DATA_W:0] fifo_q [4];
  logic [1:0]      wptr_q, rptr_q;
  logic [2:0]      cnt_q;

  logic wr_hs_s, iss_ok_s, room_s, issue_s, pop_s, release_s;

  assign s_ready   = (bank_q[wr_bank_q] == B_EMPTY);
  assign wr_hs_s   = s_valid & s_ready;
  // The issue pointer may run one bank ahead of the release pointer; a bank still
  // draining from its previous frame must not be re-entered until it is refilled.
  assign iss_ok_s  = (bank_q[iss_bank_q] == B_FULL) ||
                     ((bank_q[iss_bank_q] == B_READING) && (iss_cnt_q != {CW{1'b0}}));
  assign room_s    = ((cnt_q + {2'b00, infl_q}) < 3'd4);
  assign issue_s   = iss_ok_s & room_s;
  assign m_valid   = (cnt_q != 3'd0);
  assign m_data    = fifo_q[rptr_q][DATA_W-1:0];
  assign m_last    = m_valid & fifo_q[rptr_q][DATA_W];
  assign pop_s     = m_valid & m_ready;
  assign release_s = pop_s & m_last;

  assign ram_cea    = wr_hs_s;
  assign ram_wrea   = wr_hs_s;
  assign ram_ada    = ({9'd0, wr_bank_q} << CW) | {{(10-CW){1'b0}}, wr_cnt_q};
  assign ram_dina   = s_data;
  assign ram_ceb    = issue_s;
  assign ram_adb    = ({9'd0, iss_bank_q} << CW) | {{(10-CW){1'b0}}, iss_cnt_q};
  assign ram_wreb   = 1'b0;
  assign ram_ocea   = 1'b1;
  assign ram_oceb   = 1'b1;
  assign ram_reseta = 1'b0;
  assign ram_resetb = 1'b0;
  assign bank_full  = {(bank_q[1] != B_EMPTY), (bank_q[0] != B_EMPTY)};
  assign wr_bank    = wr_bank_q;

  // Bank, writer and reader state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q[0]   <= B_EMPTY;
      bank_q[1]   <= B_EMPTY;
      wr_bank_q   <= 1'b0;
      wr_cnt_q    <= {CW{1'b0}};
      iss_bank_q  <= 1'b0;
      iss_cnt_q   <= {CW{1'b0}};
      rd_bank_q   <= 1'b0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      bank_q[0]   <= bank_d[0];
      bank_q[1]   <= bank_d[1];
      wr_bank_q   <= wr_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      iss_bank_q  <= iss_bank_d;
      iss_cnt_q   <= iss_cnt_d;
      rd_bank_q   <= rd_bank_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
    end
  end

  // Next state; write completion, first issue and release always hit distinct banks.
  always_comb begin
    bank_d[0]   = bank_q[0];
    bank_d[1]   = bank_q[1];
    wr_bank_d   = wr_bank_q;
    wr_cnt_d    = wr_cnt_q;
    iss_bank_d  = iss_bank_q;
    iss_cnt_d   = iss_cnt_q;
    rd_bank_d   = rd_bank_q;
    infl_d      = issue_s;
    infl_last_d = issue_s && (iss_cnt_q == CNT_MAX);

    if (wr_hs_s) begin
      if (wr_cnt_q == CNT_MAX) begin
        bank_d[wr_bank_q] = B_FULL;
        wr_cnt_d          = {CW{1'b0}};
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_cnt_d = wr_cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end
    end else begin
      wr_cnt_d = wr_cnt_q;
    end

    if (issue_s) begin
      bank_d[iss_bank_q] = B_READING;
      if (iss_cnt_q == CNT_MAX) begin
        iss_cnt_d  = {CW{1'b0}};
        iss_bank_d = ~iss_bank_q;
      end else begin
        iss_cnt_d = iss_cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end
    end else begin
      iss_cnt_d = iss_cnt_q;
    end

    if (release_s) begin
      bank_d[rd_bank_q] = B_EMPTY;
      rd_bank_d         = ~rd_bank_q;
    end else begin
      rd_bank_d = rd_bank_q;
    end
  end

  // Output FIFO: captures BRAM read data the cycle after each issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) fifo_q[i] <= {(DATA_W+1){1'b0}};
      wptr_q <= 2'd0;
      rptr_q <= 2'd0;
      cnt_q  <= 3'd0;
    end else begin
      if (infl_q) begin
        fifo_q[wptr_q] <= {infl_last_q, ram_doutb};
        wptr_q         <= wptr_q + 2'd1;
      end
      if (pop_s) begin
        rptr_q <= rptr_q + 2'd1;
      end
      case ({infl_q, pop_s})
        2'b10:   cnt_q <= cnt_q + 3'd1;
        2'b01:   cnt_q <= cnt_q - 3'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_dpb_pingpong_ctrl.sv
// Directed self-checking bench for dpb_pingpong_ctrl with FRAME_LEN=4 and a BRAM model.
module tb_dpb_pingpong_ctrl;
  localparam int FL = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready = 1'b0;
  logic [9:0]    ram_ada, ram_adb;
  logic [DW-1:0] ram_dina;
  logic [DW-1:0] ram_doutb = '0;
  logic          ram_cea, ram_wrea, ram_ceb, ram_wreb;
  logic          ram_ocea, ram_oceb, ram_reseta, ram_resetb;
  logic [1:0]    bank_full;
  logic          wr_bank;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int stab_err = 0;
  logic [DW:0] got [$];
  int          stamp [$];
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  logic [DW-1:0] mem [1024];

  dpb_pingpong_ctrl #(.FRAME_LEN(FL), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .ram_ada(ram_ada), .ram_dina(ram_dina), .ram_cea(ram_cea), .ram_wrea(ram_wrea),
    .ram_adb(ram_adb), .ram_ceb(ram_ceb), .ram_wreb(ram_wreb), .ram_doutb(ram_doutb),
    .ram_ocea(ram_ocea), .ram_oceb(ram_oceb), .ram_reseta(ram_reseta),
    .ram_resetb(ram_resetb), .bank_full(bank_full), .wr_bank(wr_bank)
  );

  always #5 clk = ~clk;

  // BRAM model: synchronous write, registered read.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_cea && ram_wrea) mem[ram_ada] <= ram_dina;
    if (ram_ceb) ram_doutb <= mem[ram_adb];
  end

  // Output monitor: records accepted words and detects unstable stalled outputs.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last))
        stab_err++;
      if (m_valid && m_ready) begin
        got.push_back({m_last, m_data});
        stamp.push_back(cyc);
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    got.delete(); stamp.delete();
    @(posedge clk); #1;
  endtask

  task automatic produce(input int n, input int base);
    int i = 0;
    int budget = 0;
    logic hs;
    while (i < n && budget < 3000) begin
      s_valid = 1'b1;
      s_data  = DW'(base + i);
      @(negedge clk);
      hs = s_ready;
      @(posedge clk); #1;
      if (hs) i++;
      budget++;
    end
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s_ready, m_valid, m_last, ram_wrea, ram_cea, ram_ceb, bank_full, wr_bank} !== 9'b1_0000_0000) begin
      failures++;
      $display("FAIL reset_outputs: got %b required 100000000",
               {s_ready, m_valid, m_last, ram_wrea, ram_cea, ram_ceb, bank_full, wr_bank});
    end
    checks++;
    if ({ram_ocea, ram_oceb, ram_reseta, ram_resetb, ram_wreb} !== 5'b11000) begin
      failures++;
      $display("FAIL tied_outputs: got %b required 11000",
               {ram_ocea, ram_oceb, ram_reseta, ram_resetb, ram_wreb});
    end
  endtask

  task automatic test_single_frame();
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < FL; i++) begin
      s_valid = 1'b1; s_data = DW'(i);
      #1;
      checks++;
      if (ram_wrea !== 1'b1 || ram_cea !== 1'b1 || ram_ada !== 10'(i) || ram_dina !== DW'(i)) begin
        failures++;
        $display("FAIL write_port[%0d]: wrea=%b cea=%b ada=%0d dina=%0d required 1 1 %0d %0d",
                 i, ram_wrea, ram_cea, ram_ada, ram_dina, i, i);
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    #1;
    checks++;
    if (ram_ceb !== 1'b1 || ram_adb !== 10'd0 || m_valid !== 1'b0 || ram_wrea !== 1'b0) begin
      failures++;
      $display("FAIL first_issue_T+1: ceb=%b adb=%0d m_valid=%b wrea=%b required 1 0 0 0",
               ram_ceb, ram_adb, m_valid, ram_wrea);
    end
    @(posedge clk); #2;
    checks++;
    if (m_valid !== 1'b0) begin
      failures++;
      $display("FAIL m_valid_T+2: got %b required 0", m_valid);
    end
    for (int k = 0; k < FL; k++) begin
      @(posedge clk); #2;
      checks++;
      if (m_valid !== 1'b1 || m_data !== DW'(k) || m_last !== (k == FL - 1)) begin
        failures++;
        $display("FAIL out_T+%0d: valid=%b data=%0d last=%b required 1 %0d %b",
                 3 + k, m_valid, m_data, m_last, k, (k == FL - 1));
      end
    end
    @(posedge clk); #2;
    checks++;
    if (m_valid !== 1'b0 || bank_full !== 2'b00 || s_ready !== 1'b1) begin
      failures++;
      $display("FAIL after_frame: valid=%b bank_full=%b s_ready=%b required 0 00 1",
               m_valid, bank_full, s_ready);
    end
  endtask

  task automatic fill_both(input int base);
    for (int i = 0; i < 2 * FL; i++) begin
      s_valid = 1'b1; s_data = DW'(base + i);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic test_both_full();
    do_reset();
    fill_both(100);
    #1;
    checks++;
    if (s_ready !== 1'b0 || bank_full !== 2'b11) begin
      failures++;
      $display("FAIL both_full: s_ready=%b bank_full=%b required 0 11", s_ready, bank_full);
    end
    repeat (6) begin @(posedge clk); #1; end
    checks++;
    if (m_valid !== 1'b1 || m_data !== DW'(100) || stab_err !== 0) begin
      failures++;
      $display("FAIL stalled_head: valid=%b data=%0d stab_err=%0d required 1 100 0",
               m_valid, m_data, stab_err);
    end
    m_ready = 1'b1;
    #1;
    for (int k = 0; k < 2 * FL; k++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== DW'(100 + k) || m_last !== ((k % FL) == FL - 1)) begin
        failures++;
        $display("FAIL drain[%0d]: valid=%b data=%0d last=%b required 1 %0d %b",
                 k, m_valid, m_data, m_last, 100 + k, ((k % FL) == FL - 1));
      end
      if (k == FL - 1 || k == FL) begin
        checks++;
        if (s_ready !== (k == FL)) begin
          failures++;
          $display("FAIL s_ready_release[%0d]: got %b required %b", k, s_ready, (k == FL));
        end
      end
      @(posedge clk); #2;
    end
    checks++;
    if (m_valid !== 1'b0 || bank_full !== 2'b00) begin
      failures++;
      $display("FAIL drained: valid=%b bank_full=%b required 0 00", m_valid, bank_full);
    end
  endtask

  task automatic test_random_ready();
    do_reset();
    stab_err = 0;
    fork
      produce(10 * FL, 1000);
      for (int c = 0; c < 800 && got.size() < 10 * FL; c++) begin
        @(posedge clk); #1;
        m_ready = 1'($urandom_range(0, 1));
      end
    join
    m_ready = 1'b0;
    checks++;
    if (got.size() != 10 * FL || stab_err != 0) begin
      failures++;
      $display("FAIL random_count: words=%0d stab_err=%0d required %0d 0", got.size(), stab_err, 10 * FL);
    end
    for (int k = 0; k < got.size(); k++) begin
      checks++;
      if (got[k] !== {((k % FL) == FL - 1), DW'(1000 + k)}) begin
        failures++;
        $display("FAIL random_word[%0d]: got %h required %h", k, got[k], {((k % FL) == FL - 1), DW'(1000 + k)});
      end
    end
  endtask

  task automatic test_back_to_back();
    int gaps = 0;
    do_reset();
    m_ready = 1'b1;
    fork
      produce(20 * FL, 5000);
      for (int c = 0; c < 1500 && got.size() < 20 * FL; c++) begin
        @(posedge clk); #1;
      end
    join
    checks++;
    if (got.size() != 20 * FL) begin
      failures++;
      $display("FAIL b2b_count: words=%0d required %0d", got.size(), 20 * FL);
    end
    for (int k = 0; k < got.size(); k++) begin
      checks++;
      if (got[k] !== {((k % FL) == FL - 1), DW'(5000 + k)}) begin
        failures++;
        $display("FAIL b2b_word[%0d]: got %h required %h", k, got[k], {((k % FL) == FL - 1), DW'(5000 + k)});
      end
      if ((k % FL) != 0 && stamp[k] != stamp[k-1] + 1) gaps++;
    end
    checks++;
    if (gaps != 0) begin
      failures++;
      $display("FAIL b2b_in_frame_gaps: got %0d required 0", gaps);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_ready = 1'b1;
    produce(FL + 2, 'h50);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s_ready, m_valid, m_last, ram_wrea, ram_cea, ram_ceb, bank_full, wr_bank} !== 9'b1_0000_0000) begin
      failures++;
      $display("FAIL mid_reset_outputs: got %b required 100000000",
               {s_ready, m_valid, m_last, ram_wrea, ram_cea, ram_ceb, bank_full, wr_bank});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    got.delete(); stamp.delete();
    produce(FL, 'hA);
    checks++;
    if (bank_full !== 2'b01 || wr_bank !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_bank: bank_full=%b wr_bank=%b required 01 1", bank_full, wr_bank);
    end
    for (int c = 0; c < 50 && got.size() < FL; c++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (got.size() != FL) begin
      failures++;
      $display("FAIL post_reset_count: words=%0d required %0d", got.size(), FL);
    end
    for (int k = 0; k < got.size(); k++) begin
      checks++;
      if (got[k] !== {(k == FL - 1), DW'('hA + k)}) begin
        failures++;
        $display("FAIL post_reset_word[%0d]: got %h required %h", k, got[k], {(k == FL - 1), DW'('hA + k)});
      end
    end
  endtask

  task automatic test_hold_full();
    int wr_seen = 0;
    bit found = 0;
    do_reset();
    fill_both(200);
    s_valid = 1'b1; s_data = DW'('hDEAD);
    for (int c = 0; c < 10; c++) begin
      #1;
      if (ram_wrea !== 1'b0 || ram_cea !== 1'b0 || s_ready !== 1'b0) wr_seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (wr_seen != 0) begin
      failures++;
      $display("FAIL hold_no_write: bad_cycles=%0d required 0", wr_seen);
    end
    m_ready = 1'b1;
    for (int c = 0; c < 40 && !found; c++) begin
      #1;
      if (ram_wrea === 1'b1) begin
        found = 1;
        checks++;
        if (ram_ada !== 10'd0 || ram_dina !== DW'('hDEAD)) begin
          failures++;
          $display("FAIL held_sample_write: ada=%0d dina=%h required 0 dead", ram_ada, ram_dina);
        end
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL held_sample_timeout: no write within 40 cycles");
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_both_full();
    test_random_ready();
    test_back_to_back();
    test_reset_mid();
    test_hold_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
